// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the writeback sources and the register-file write arbiter.
// master = requester/bench side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 16
);
    logic                      hold;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_write_en;
    logic [ADDR_W-1:0]         rf_write_addr;
    logic [DATA_W-1:0]         rf_write_data;
    logic [15:0]               write_count;

    modport master (
        output hold, req_valid, req_addr, req_data,
        input  req_ready, rf_write_en, rf_write_addr, rf_write_data, write_count
    );

    modport slave (
        input  hold, req_valid, req_addr, req_data,
        output req_ready, rf_write_en, rf_write_addr, rf_write_data, write_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single register-file write port (fixed priority, or round robin with ARB_ROUND_ROBIN_EN).
// Latency: transfer in cycle T gives a one-cycle rf_write_en pulse after edge T+1; one write per cycle.
// Backpressure: req_ready is a one-hot combinational grant, all zero while hold or reset is high.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 16
) (
    input  logic clk,
    input  logic reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_found;
    logic               arb_en;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    logic               write_en_q;
    logic [ADDR_W-1:0]  write_addr_q;
    logic [DATA_W-1:0]  write_data_q;
    logic [15:0]        write_count_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]   ptr_q;
`endif

    // Search starts at the pointer (round robin) or at source 0 (fixed); first valid wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
`else
            idx = k;
`endif
            if (!grant_found && bus.req_valid[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = PTR_W'(idx);
                grant_found = 1'b1;
            end
        end
    end

    // Reset also blocks grants so nothing pending is accepted while it is held.
    assign arb_en        = !reset && !bus.hold;
    assign bus.req_ready = arb_en ? grant : '0;
    assign xfer          = arb_en && grant_found;

    assign sel_addr = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data = bus.req_data[grant_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_en_q    <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            write_count_q <= '0;
        end else begin
            write_en_q <= xfer;
            if (xfer) begin
                write_addr_q  <= sel_addr;
                write_data_q  <= sel_data;
                write_count_q <= write_count_q + 16'd1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Winner drops to lowest priority for the next cycle; no grant leaves the pointer alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end
`endif

    assign bus.rf_write_en   = write_en_q;
    assign bus.rf_write_addr = write_addr_q;
    assign bus.rf_write_data = write_data_q;
    assign bus.write_count   = write_count_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected writes are queued at grant time and checked at the pulse.
// Builds for either arbitration mode (ARB_ROUND_ROBIN_EN) and adjusts its expected grant order to match.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NUM_REQ(3), .ADDR_W(3), .DATA_W(16)) bus ();

    regfile_write_arbiter #(.NUM_REQ(3), .ADDR_W(3), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         q[$];
    wr_t         last_wr;
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_count = 16'd0;
    logic [2:0]  src_addr[3];
    logic [15:0] src_data[3];
    logic [15:0] rf[8];
    logic [2:0]  exp_seq[6];

    assign bus.req_addr = {src_addr[2], src_addr[1], src_addr[0]};
    assign bus.req_data = {src_data[2], src_data[1], src_data[0]};

    // Register-file model: commits whatever the write port presents.
    always @(posedge clk) begin
        if (bus.rf_write_en) rf[bus.rf_write_addr] <= bus.rf_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check the grant, queue the expected write, then check the write port after the edge.
    task automatic cycle(input logic [2:0] exp_rdy, input string tag);
        wr_t w;
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
        for (int i = 0; i < 3; i++) begin
            if (exp_rdy[i]) begin
                q.push_back('{a: src_addr[i], d: src_data[i]});
                exp_count++;
            end
        end
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            w = q.pop_front();
            chk({tag, "_en"},   32'(bus.rf_write_en),   32'd1);
            chk({tag, "_addr"}, 32'(bus.rf_write_addr), 32'(w.a));
            chk({tag, "_data"}, 32'(bus.rf_write_data), 32'(w.d));
            last_wr = w;
        end else begin
            chk({tag, "_en"},   32'(bus.rf_write_en),   32'd0);
            chk({tag, "_addr"}, 32'(bus.rf_write_addr), 32'(last_wr.a));
            chk({tag, "_data"}, 32'(bus.rf_write_data), 32'(last_wr.d));
        end
        chk({tag, "_count"}, 32'(bus.write_count), 32'(exp_count));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        last_wr       = '0;
        reset         = 1'b1;
        bus.hold      = 1'b0;
        bus.req_valid = 3'b111;
        src_addr[0] = 3'd1; src_data[0] = 16'h1111;
        src_addr[1] = 3'd2; src_data[1] = 16'h2222;
        src_addr[2] = 3'd3; src_data[2] = 16'h3333;

        // Reset with all sources requesting.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready),     32'd0);
        chk("rst_en",    32'(bus.rf_write_en),   32'd0);
        chk("rst_addr",  32'(bus.rf_write_addr), 32'd0);
        chk("rst_data",  32'(bus.rf_write_data), 32'd0);
        chk("rst_count", 32'(bus.write_count),   32'd0);
        reset = 1'b0;
        cycle(3'b001, "release");

        // Single source 1 write, then idle to see the pulse end.
        bus.req_valid = 3'b010;
        src_addr[1] = 3'd5; src_data[1] = 16'hBEEF;
        cycle(3'b010, "src1");
        bus.req_valid = 3'b000;
        cycle(3'b000, "src1_idle");

        bus.req_valid = 3'b100;
        cycle(3'b100, "src2");

        // All three valid for six cycles.
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        src_addr[1] = 3'd2; src_data[1] = 16'h2222;
        bus.req_valid = 3'b111;
        for (int i = 0; i < 6; i++) cycle(exp_seq[i], "all3");

        // Park the pointer on source 1, then hold with everyone requesting.
        bus.req_valid = 3'b001;
        cycle(3'b001, "pre_hold");
        bus.req_valid = 3'b111;
        bus.hold      = 1'b1;
        for (int i = 0; i < 4; i++) cycle(3'b000, "hold");
        bus.hold = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        cycle(3'b010, "resume");
`else
        cycle(3'b001, "resume");
`endif
        bus.req_valid = 3'b000;
        cycle(3'b000, "resume_idle");

        // Fill the counter to FFFF, then wrap it.
        src_addr[0] = 3'd4; src_data[0] = 16'h4444;
        bus.req_valid = 3'b001;
        while (exp_count != 16'hFFFF) cycle(3'b001, "fill");
        cycle(3'b001, "wrap");
        bus.req_valid = 3'b000;
        cycle(3'b000, "wrap_idle");

        // Reset lands after the grant but before the capturing edge.
        src_addr[0] = 3'd6; src_data[0] = 16'h1234;
        bus.req_valid = 3'b001;
        #1;
        chk("mid_rst_grant", 32'(bus.req_ready), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("mid_rst_en",    32'(bus.rf_write_en),   32'd0);
            chk("mid_rst_count", 32'(bus.write_count),   32'd0);
            chk("mid_rst_addr",  32'(bus.rf_write_addr), 32'd0);
        end
        chk("mid_rst_rf6", 32'(rf[6]), 32'd0);
        exp_count = 16'd0;
        last_wr   = '0;

        // Pointer must restart at source 0.
        bus.req_valid = 3'b111;
        reset = 1'b0;
        cycle(3'b001, "post_rst");
        bus.req_valid = 3'b000;
        cycle(3'b000, "post_rst_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
